// File: rtl/gcd_datapath.sv
// Operand/arithmetic half of the GCD engine: captures an operand pair, runs
// subtractive Euclid steps while the controller reports COMPUTE, holds the result.
module gcd_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [1:0]            state_i,
  output logic                  compare_zero_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic [ITER_WIDTH-1:0] iter_count_o,
  output logic                  busy_o
);

  localparam logic [1:0] ST_COMPUTE = 2'b01;
  localparam logic [1:0] ST_FINISH  = 2'b10;

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  valid_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic                  armed_q;

  // Registers only, so the controller never sees a combinational path from our inputs.
  assign compare_zero_o = (a_q == '0) || (b_q == '0);

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign iter_count_o   = iter_q;
  assign busy_o         = armed_q;

  // result_valid_o is a level: it rises once per armed operation and stays high
  // until the next load_i or reset; there is no ready/acknowledge from the host.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      iter_q   <= '0;
      armed_q  <= 1'b0;
    end else if (load_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      iter_q  <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b1;
    end else if (state_i == ST_COMPUTE && !compare_zero_o) begin
      if (a_q >= b_q) begin
        a_q <= a_q - b_q;
      end else begin
        b_q <= b_q - a_q;
      end
      if (iter_q != '1) begin
        iter_q <= iter_q + ITER_WIDTH'(1);
      end
    end else if (state_i == ST_FINISH && armed_q && compare_zero_o) begin
      // One operand is zero, so OR yields the survivor (or 0 when both are zero).
      result_q <= a_q | b_q;
      valid_q  <= 1'b1;
      armed_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath: drives the controller state code by hand
// and compares against hand-derived Euclid traces and results.
module tb_gcd_datapath;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam logic [1:0] ST_INIT    = 2'b00;
  localparam logic [1:0] ST_COMPUTE = 2'b01;
  localparam logic [1:0] ST_FINISH  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          load_i;
  logic [DW-1:0] a_i;
  logic [DW-1:0] b_i;
  logic [1:0]    state_i;
  logic          compare_zero_o;
  logic [DW-1:0] result_o;
  logic          result_valid_o;
  logic [IW-1:0] iter_count_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;
  int n_steps;

  // Expected {a_q, b_q} after each Euclid step of the traced operation.
  logic [2*DW-1:0] exp_q[$];

  gcd_datapath #(.DATA_WIDTH(DW), .ITER_WIDTH(IW)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .load_i         (load_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .state_i        (state_i),
    .compare_zero_o (compare_zero_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .iter_count_o   (iter_count_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    load_i  = 1'b1;
    a_i     = a;
    b_i     = b;
    state_i = ST_INIT;
    step();
    load_i  = 1'b0;
  endtask

  // Steps in COMPUTE until compare_zero_o, bounded by budget cycles.
  task automatic compute(input int budget, output int n);
    logic [2*DW-1:0] exp_ab;
    state_i = ST_COMPUTE;
    n = 0;
    while (compare_zero_o == 1'b0 && n < budget) begin
      step();
      n++;
      if (exp_q.size() > 0) begin
        exp_ab = exp_q.pop_front();
        check("trace_ab", {dut.a_q, dut.b_q}, exp_ab);
      end
    end
    check("compute_done", compare_zero_o, 1);
    state_i = ST_INIT;
  endtask

  task automatic finish_op();
    state_i = ST_FINISH;
    step();
    state_i = ST_INIT;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_valid"}, result_valid_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_cz"},    compare_zero_o, 1);
    check({tag, "_res"},   result_o, 0);
    check({tag, "_iter"},  iter_count_o, 0);
  endtask

  initial begin
    reset_i = 1'b1;
    load_i  = 1'b0;
    a_i     = '0;
    b_i     = '0;
    state_i = ST_INIT;
    #3;
    check_idle_reset("rst");
    step();
    step();
    reset_i = 1'b0;

    // FINISH after reset must not produce a result: nothing is armed.
    state_i = ST_FINISH;
    for (int i = 0; i < 10; i++) step();
    check_idle_reset("finish_unarmed");
    state_i = ST_INIT;

    // (48,18): 30/18, 12/18, 12/6, 6/6, 0/6 -> gcd 6 in 5 steps.
    load_pair(8'd48, 8'd18);
    check("load_busy", busy_o, 1);
    check("load_cz", compare_zero_o, 0);
    check("load_iter", iter_count_o, 0);
    step();
    exp_q = '{{8'd30, 8'd18}, {8'd12, 8'd18}, {8'd12, 8'd6}, {8'd6, 8'd6}, {8'd0, 8'd6}};
    compute(300, n_steps);
    check("g48_steps", n_steps, 5);
    check("g48_pre_valid", result_valid_o, 0);
    finish_op();
    check("g48_valid", result_valid_o, 1);
    check("g48_res", result_o, 6);
    check("g48_iter", iter_count_o, 5);
    check("g48_busy", busy_o, 0);

    // Result is held across unrelated state codes.
    state_i = ST_COMPUTE;
    step();
    state_i = ST_ILLEGAL;
    step();
    state_i = ST_INIT;
    for (int i = 0; i < 3; i++) step();
    check("hold_valid", result_valid_o, 1);
    check("hold_res", result_o, 6);

    // (7,0): zero operand, no steps, result is the other operand.
    load_pair(8'd7, 8'd0);
    check("z7_cz", compare_zero_o, 1);
    check("z7_valid", result_valid_o, 0);
    state_i = ST_COMPUTE;
    for (int i = 0; i < 3; i++) step();
    check("z7_iter_c", iter_count_o, 0);
    check("z7_a", dut.a_q, 7);
    finish_op();
    check("z7_valid2", result_valid_o, 1);
    check("z7_res", result_o, 7);
    check("z7_iter", iter_count_o, 0);

    // (0,0): result 0 with valid.
    load_pair(8'd0, 8'd0);
    finish_op();
    check("zz_valid", result_valid_o, 1);
    check("zz_res", result_o, 0);

    // a == b: single step, result b.
    load_pair(8'd5, 8'd5);
    compute(300, n_steps);
    finish_op();
    check("eq_iter", iter_count_o, 1);
    check("eq_res", result_o, 5);

    // (255,1): a decrements by 1 each step.
    load_pair(8'd255, 8'd1);
    compute(300, n_steps);
    finish_op();
    check("big_iter", iter_count_o, 255);
    check("big_res", result_o, 1);
    check("big_valid", result_valid_o, 1);

    // Reload mid-operation: load wins over COMPUTE on the same edge.
    load_pair(8'd48, 8'd18);
    state_i = ST_COMPUTE;
    step();
    step();
    check("mid_iter2", iter_count_o, 2);
    load_i = 1'b1;
    a_i    = 8'd9;
    b_i    = 8'd6;
    step();
    load_i = 1'b0;
    check("reload_iter", iter_count_o, 0);
    check("reload_valid", result_valid_o, 0);
    check("reload_ab", {dut.a_q, dut.b_q}, {8'd9, 8'd6});
    // (9,6): 3/6, 3/3, 0/3 -> gcd 3 in 3 steps.
    exp_q = '{{8'd3, 8'd6}, {8'd3, 8'd3}, {8'd0, 8'd3}};
    compute(300, n_steps);
    check("reload_valid2", result_valid_o, 0);
    finish_op();
    check("g9_res", result_o, 3);
    check("g9_iter", iter_count_o, 3);

    // load_i held high under COMPUTE: operands re-captured, no stepping.
    load_i  = 1'b1;
    state_i = ST_COMPUTE;
    a_i = 8'd20; b_i = 8'd4;
    step();
    a_i = 8'd21; b_i = 8'd14;
    step();
    a_i = 8'd10; b_i = 8'd4;
    step();
    load_i = 1'b0;
    check("held_iter", iter_count_o, 0);
    check("held_ab", {dut.a_q, dut.b_q}, {8'd10, 8'd4});

    // FINISH while operands are nonzero: hold and wait.
    state_i = ST_FINISH;
    step();
    step();
    check("early_fin_valid", result_valid_o, 0);
    check("early_fin_busy", busy_o, 1);
    check("early_fin_ab", {dut.a_q, dut.b_q}, {8'd10, 8'd4});
    compute(300, n_steps);
    finish_op();
    check("g10_res", result_o, 2);
    check("g10_iter", iter_count_o, 4);

    // Asynchronous reset in the middle of a computation.
    load_pair(8'd200, 8'd3);
    state_i = ST_COMPUTE;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_iter", iter_count_o, 5);
    #1;
    reset_i = 1'b1;
    #1;
    check_idle_reset("async_rst");
    step();
    reset_i = 1'b0;
    state_i = ST_FINISH;
    for (int i = 0; i < 3; i++) step();
    check_idle_reset("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
